// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//
// Request/result bundle for the bit-serial subtractor.
//
// Signals:
//   start  - request pulse; operands are sampled on the accepting edge
//   a      - minuend (WIDTH bits)
//   b      - subtrahend (WIDTH bits)
//   busy   - high while a subtraction is in progress
//   done   - one-cycle completion pulse
//   diff   - A - B modulo 2^WIDTH, held until the next completion
//   borrow - final borrow (1 when A < B), held with diff
//
// Modports:
//   master - the requester (drives start/a/b, observes results)
//   slave  - the subtractor itself
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: computes A - B for two WIDTH-bit unsigned operands,
// LSB first, one bit per clock, using a single full-subtractor cell and a
// registered borrow. Subtract direction of the half-adder arithmetic path.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous, active-low reset
//   bus    - serial_subtractor_if.slave (start, a, b, busy, done, diff, borrow)
//
// Timing: start accepted at edge N -> done high in the cycle after edge
// N+WIDTH. A start seen during the done cycle restarts immediately.
//
// Optional feature (compile-time macro SERIAL_SUBTRACTOR_SAT_EN):
//   defined     - a result with final borrow = 1 is clamped to 0
//                 (saturating unsigned subtract); borrow still reads 1.
//   not defined - diff is the wrapped modulo-2^WIDTH result.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-2:0]  r_sh;
    logic              br;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  diff_q;
    logic              borrow_q;

    logic              d;
    logic              br_next;
    logic [WIDTH-1:0]  result;
    logic              last_bit;
    logic              accept;
    logic              busy_c;
    logic              done_c;

    // Full-subtractor cell on the current LSBs plus the registered borrow.
    // The result register only keeps the WIDTH-1 bits already produced;
    // prepending the bit computed this cycle forms the complete word, so
    // on the last bit 'result' is exactly the value to publish.
    always_comb begin
        d        = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        result   = {d, r_sh};
        last_bit = (cnt == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode. busy/done depend only on the state
    // register so there is no combinational path from inputs to outputs.
    // A start in the done cycle is accepted so back-to-back requests have
    // no idle bubble; a start during RUN is simply not looked at.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load operands on acceptance, shift one bit per RUN cycle,
    // and publish diff/borrow only on the edge that enters DONE so the
    // outputs stay stable while the next operation is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            r_sh <= result[WIDTH-1:1];
            br   <= br_next;
            cnt  <= cnt + 1'b1;
            if (last_bit) begin
`ifdef SERIAL_SUBTRACTOR_SAT_EN
                diff_q <= br_next ? '0 : result;
`else
                diff_q <= result;
`endif
                borrow_q <= br_next;
            end
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH = 4). Directed vectors
// with hand-computed results; each accepted request pushes its expected
// diff/borrow and expected done cycle into a queue, and an independent
// monitor pops and compares whenever done is seen.
// Honours SERIAL_SUBTRACTOR_SAT_EN when computing clamped expectations.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int WIDTH = 4;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to timestamp expected completions.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Applies the saturation clamp when the optional feature is built in.
    function automatic logic [WIDTH-1:0] expDiff(input logic [WIDTH-1:0] wrap,
                                                 input logic br);
        return (SAT && br) ? '0 : wrap;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge. Drives start for one edge; when push is set the
    // expected result is queued for done at (accepting edge) + WIDTH.
    // Returns at the following negedge with start low.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic [WIDTH-1:0] wrap, input logic br,
                                 input bit push);
        exp_t e;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        if (push) begin
            e.diff   = expDiff(wrap, br);
            e.borrow = br;
            e.cyc    = cyc + 1 + WIDTH;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Bounded wait for a done pulse; returns at the negedge where done is high.
    task automatic waitDone();
        int n = 0;
        while (bus.done !== 1'b1 && n < 4 * WIDTH + 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_timeout", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_busy"},   {31'd0, bus.busy},   32'd0);
        checkOutput({tag, "_done"},   {31'd0, bus.done},   32'd0);
        checkOutput({tag, "_diff"},   32'(bus.diff),       32'd0);
        checkOutput({tag, "_borrow"}, {31'd0, bus.borrow}, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request,
    // including the cycle it arrives in and busy being low alongside it.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending request (cyc=%0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_diff",   32'(bus.diff),       32'(e.diff));
                checkOutput("sb_borrow", {31'd0, bus.borrow}, {31'd0, e.borrow});
                checkOutput("sb_cycle",  32'(cyc),            32'(e.cyc));
                checkOutput("sb_busy",   {31'd0, bus.busy},   32'd0);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state, then ten quiet cycles.
        repeat (3) @(negedge clk);
        checkIdleZero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkIdleZero("idle_hold");

        // Basic 9 - 3: busy for WIDTH cycles, result held afterwards.
        applyStimulus(4'd9, 4'd3, 4'd6, 1'b0, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput("run_busy", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        waitDone();
        repeat (10) @(negedge clk);
        checkOutput("hold_diff",   32'(bus.diff),       32'd6);
        checkOutput("hold_borrow", {31'd0, bus.borrow}, 32'd0);

        // Underflow and edge operands.
        applyStimulus(4'd3,  4'd9,  4'd10, 1'b1, 1'b1); waitDone(); @(negedge clk);
        applyStimulus(4'd0,  4'd0,  4'd0,  1'b0, 1'b1); waitDone(); @(negedge clk);
        applyStimulus(4'd15, 4'd15, 4'd0,  1'b0, 1'b1); waitDone(); @(negedge clk);
        applyStimulus(4'd0,  4'd1,  4'd15, 1'b1, 1'b1); waitDone(); @(negedge clk);

        // start mid-RUN ignored; start in the done cycle restarts at once.
        applyStimulus(4'd9, 4'd3, 4'd6, 1'b0, 1'b1);
        applyStimulus(4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
        waitDone();
        applyStimulus(4'd12, 4'd5, 4'd7, 1'b0, 1'b1);
        checkOutput("b2b_busy", {31'd0, bus.busy}, 32'd1);
        waitDone();
        @(negedge clk);

        // Reset on the second RUN cycle aborts with no done pulse.
        applyStimulus(4'd9, 4'd3, 4'd6, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkIdleZero("abort_in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkIdleZero("abort_after");

        // Fresh operation after the abort.
        applyStimulus(4'd5, 4'd2, 4'd3, 1'b0, 1'b1);
        waitDone();
        repeat (3) @(negedge clk);

        checkOutput("pending_left", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
